// File: rtl/alu_seq_exec.sv
// alu_seq_exec: handshaked ALU; add/sub finish in one cycle, mul is shift-add, div is restoring.
module alu_seq_exec #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [2:0]       alu_control,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dz,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_r, b_r, hi, lo, hi_n, lo_n, fast_res, d_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0] dec;
  logic [WIDTH:0] add_s, m_sum, d_t;
  logic is_mul, iter, d_ge;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  // hi/lo hold the running product (mul) or partial remainder/quotient (div)
  always_comb begin
    dec      = alu_op == 2'b00 ? {1'b0, op} : 3'b111;
    iter     = dec == 3'b010 || (dec == 3'b011 && src_b != '0);
    add_s    = {1'b0, src_a} + {1'b0, src_b};
    fast_res = dec == 3'b000 ? add_s[WIDTH-1:0] : dec == 3'b001 ? src_a - src_b : dec == 3'b011 ? '1 : src_a;
    is_mul   = alu_control == 3'b010;
    m_sum    = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : '0);
    d_t      = {hi, lo[WIDTH-1]};
    d_ge     = d_t >= {1'b0, b_r};
    d_d      = d_t[WIDTH-1:0] - b_r;
    hi_n     = is_mul ? m_sum[WIDTH:1] : d_ge ? d_d : d_t[WIDTH-1:0];
    lo_n     = is_mul ? {m_sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], d_ge};
    state_n  = state == IDLE ? (in_valid ? (iter ? CALC : DONE) : IDLE) :
               state == CALC ? (cnt == CNT_W'(1) ? DONE : CALC) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_control <= 3'b111;
      result      <= '0;
      remainder   <= '0;
      flag_zero   <= 1'b0;
      flag_carry  <= 1'b0;
      flag_ovf    <= 1'b0;
      flag_dz     <= 1'b0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      a_r         <= '0;
      b_r         <= '0;
    end else if (state == IDLE && in_valid) begin
      alu_control <= dec;
      a_r         <= src_a;
      b_r         <= src_b;
      cnt         <= CNT_W'(WIDTH);
      hi          <= '0;
      lo          <= dec == 3'b010 ? src_b : src_a;
      if (!iter) begin
        result     <= fast_res;
        remainder  <= dec == 3'b011 ? src_a : '0;
        flag_zero  <= fast_res == '0;
        flag_carry <= dec == 3'b000 ? add_s[WIDTH] : dec == 3'b001 && src_a < src_b;
        flag_ovf   <= 1'b0;
        flag_dz    <= dec == 3'b011;
      end
    end else if (state == CALC) begin
      cnt <= cnt - 1'b1;
      hi  <= hi_n;
      lo  <= lo_n;
      if (cnt == CNT_W'(1)) begin
        result     <= lo_n;
        remainder  <= is_mul ? '0 : hi_n;
        flag_zero  <= lo_n == '0;
        flag_carry <= 1'b0;
        flag_ovf   <= is_mul && |hi_n;
        flag_dz    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: scoreboard bench for 8-bit and 16-bit instances of alu_seq_exec.
module tb_alu_seq_exec;
  typedef struct packed {
    logic [15:0] res;
    logic [15:0] rem;
    logic [2:0]  ctrl;
    logic        z, c, o, dz;
    int          lat;
    int          acc;
  } exp_t;

  logic clk, rst_n, iv0, iv1, ordy;
  logic [1:0] alu_op, op;
  logic [15:0] src_a, src_b;
  logic ir0, ov0, z0, c0, o0, dz0, bz0;
  logic ir1, ov1, z1, c1, o1, dz1, bz1;
  logic [7:0] r0, rm0;
  logic [15:0] r1, rm1;
  logic [2:0] ct0, ct1;
  int checks = 0, fails = 0, cyc = 0;
  bit rnd_bp = 0;
  bit pv [2];
  exp_t q0[$], q1[$];

  alu_seq_exec #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .alu_op(alu_op), .op(op),
    .src_a(src_a[7:0]), .src_b(src_b[7:0]), .out_valid(ov0), .out_ready(ordy), .result(r0),
    .remainder(rm0), .alu_control(ct0), .flag_zero(z0), .flag_carry(c0), .flag_ovf(o0),
    .flag_dz(dz0), .busy(bz0));

  alu_seq_exec #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .alu_op(alu_op), .op(op),
    .src_a(src_a), .src_b(src_b), .out_valid(ov1), .out_ready(ordy), .result(r1),
    .remainder(rm1), .alu_control(ct1), .flag_zero(z1), .flag_carry(c1), .flag_ovf(o1),
    .flag_dz(dz1), .busy(bz1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(int k, string n, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL dut%0d %s actual=%0h required=%0h", k, n, act, req);
    end
  endfunction

  // Reference behaviour from the arithmetic definitions at width w
  function automatic exp_t model(int w, logic [1:0] ao, logic [1:0] o, logic [15:0] a, logic [15:0] b);
    exp_t e;
    longint m, p;
    m = (longint'(1) << w) - 1;
    e.ctrl = ao != 2'b00 ? 3'd7 : {1'b0, o};
    e.res = a; e.rem = 0; e.c = 0; e.o = 0; e.dz = 0; e.lat = 1; e.acc = 0;
    if (ao == 2'b00) begin
      if (o == 2'd0) begin
        p = longint'(a) + longint'(b);
        e.res = 16'(p & m);
        e.c = p > m;
      end else if (o == 2'd1) begin
        e.res = 16'((longint'(a) - longint'(b)) & m);
        e.c = a < b;
      end else if (o == 2'd2) begin
        p = longint'(a) * longint'(b);
        e.res = 16'(p & m);
        e.o = (p >> w) != 0;
        e.lat = w + 1;
      end else if (b == 16'd0) begin
        e.res = 16'(m);
        e.rem = a;
        e.dz = 1;
      end else begin
        e.res = a / b;
        e.rem = a % b;
        e.lat = w + 1;
      end
    end
    e.z = e.res == 16'd0;
    return e;
  endfunction

  task automatic issue(input int k, input logic [1:0] ao, input logic [1:0] o,
                       input logic [15:0] a, input logic [15:0] b, input bit push);
    exp_t e;
    int t;
    logic [15:0] am, bm;
    am = k != 0 ? a : (a & 16'h00FF);
    bm = k != 0 ? b : (b & 16'h00FF);
    e = model(k != 0 ? 16 : 8, ao, o, am, bm);
    @(negedge clk);
    alu_op = ao; op = o; src_a = a; src_b = b;
    if (k != 0) iv1 = 1; else iv0 = 1;
    t = 0;
    while (!(k != 0 ? ir1 : ir0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 300) begin
      fails++;
      $display("FAIL dut%0d accept_timeout actual=not_ready required=ready", k);
    end else begin
      e.acc = cyc + 1;
      if (push && k != 0) q1.push_back(e);
      else if (push) q0.push_back(e);
    end
    @(negedge clk);
    iv0 = 0; iv1 = 0;
  endtask

  task automatic mon(input int k, input logic ov, input logic ir, input logic bz,
                     input logic [15:0] r, input logic [15:0] rm, input logic [2:0] ct,
                     input logic z, input logic c, input logic o, input logic dz);
    exp_t e;
    if (!ov) begin
      pv[k] = 0;
      return;
    end
    if ((k != 0 ? q1.size() : q0.size()) == 0) begin
      checks++;
      fails++;
      $display("FAIL dut%0d spurious_output actual=out_valid required=idle", k);
      pv[k] = 1;
      return;
    end
    e = k != 0 ? q1[0] : q0[0];
    if (!pv[k]) chk(k, "latency", 64'(cyc - e.acc + 1), 64'(e.lat));
    pv[k] = 1;
    chk(k, "result", r, e.res);
    chk(k, "remainder", rm, e.rem);
    chk(k, "alu_control", ct, e.ctrl);
    chk(k, "flags_zcod", {z, c, o, dz}, {e.z, e.c, e.o, e.dz});
    chk(k, "ready_busy_in_done", {ir, bz}, 2'b01);
  endtask

  always @(negedge clk) begin
    mon(0, ov0, ir0, bz0, {8'h00, r0}, {8'h00, rm0}, ct0, z0, c0, o0, dz0);
    mon(1, ov1, ir1, bz1, r1, rm1, ct1, z1, c1, o1, dz1);
  end

  always @(posedge clk) begin
    if (ov0 && ordy && q0.size() > 0) void'(q0.pop_front());
    if (ov1 && ordy && q1.size() > 0) void'(q1.pop_front());
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_bp) ordy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [1:0] ao;
    int t;
    rst_n = 0; iv0 = 0; iv1 = 0; ordy = 1; alu_op = 0; op = 0; src_a = 0; src_b = 0;
    repeat (3) @(negedge clk);
    chk(0, "rst_state", {ir0, ov0, bz0, ct0, r0, rm0, z0, c0, o0, dz0}, {3'b100, 3'b111, 20'h0});
    chk(1, "rst_state", {ir1, ov1, bz1, ct1, r1, rm1, z1, c1, o1, dz1}, {3'b100, 3'b111, 36'h0});
    rst_n = 1;
    issue(0, 2'b00, 2'b11, 16'd200, 16'd7, 0);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk(0, "rst_mid_div", {ov0, ir0, bz0, ct0}, {3'b010, 3'b111});
    rst_n = 1;
    repeat (12) @(negedge clk);
    issue(0, 2'b00, 2'b00, 16'hF0, 16'h20, 1);
    issue(0, 2'b00, 2'b01, 16'h05, 16'h05, 1);
    issue(0, 2'b00, 2'b01, 16'h03, 16'h05, 1);
    issue(0, 2'b00, 2'b10, 16'd13, 16'd11, 1);
    issue(0, 2'b00, 2'b10, 16'h40, 16'h04, 1);
    issue(0, 2'b00, 2'b11, 16'd200, 16'd7, 1);
    issue(0, 2'b00, 2'b11, 16'd9, 16'd0, 1);
    for (int i = 1; i < 4; i++)
      for (int j = 0; j < 3; j++) issue(0, 2'(i), 2'(j), 16'h3C, 16'h11, 1);
    issue(1, 2'b00, 2'b10, 16'd1000, 16'd300, 1);
    issue(1, 2'b00, 2'b11, 16'd60000, 16'd7, 1);
    issue(1, 2'b00, 2'b11, 16'd5, 16'd0, 1);
    ordy = 0;
    issue(0, 2'b00, 2'b10, 16'd13, 16'd11, 1);
    fork
      begin
        repeat (14) @(negedge clk);
        ordy = 1;
      end
      issue(0, 2'b00, 2'b00, 16'h12, 16'h34, 1);
    join
    rnd_bp = 1;
    for (int i = 0; i < 150; i++) begin
      ao = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      issue(0, ao, 2'($urandom), 16'($urandom), $urandom_range(0, 7) == 0 ? 16'h0 : 16'($urandom), 1);
    end
    for (int i = 0; i < 40; i++) begin
      ao = $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      issue(1, ao, 2'($urandom), 16'($urandom), $urandom_range(0, 7) == 0 ? 16'h0 : 16'($urandom), 1);
    end
    rnd_bp = 0;
    @(negedge clk);
    ordy = 1;
    t = 0;
    while ((q0.size() > 0 || q1.size() > 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(0, "drain_pending", 64'(q0.size() + q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
